store_size_unit: RTL and testbench
==================================

// Module: store_size_unit
// PURPOSE
// - Store-path counterpart of the load sign/zero extender: narrows a 32-bit register value to a word, halfword or byte.
// - Writes it into a word-addressed data memory by read-modify-write, preserving the untouched bytes.
// - Sits between the control FSM (start/done handshake) and the data-memory port in the multicycle datapath.
// - Little-endian lanes: addr[1:0]=0 selects bits 7:0.
// PARAMETERS
// - MEM_LATENCY  1  cycles from mem_addr presented (mem_wr=0) to mem_rdata valid; legal range 1..7
// PORTS
// - clk        in   1   system clock, all state on rising edge
// - reset      in   1   synchronous, active-high
// - start      in   1   request; sampled only in IDLE
// - op         in   2   00=SW, 01=SH, 10=SB, 11=reserved (treated as error)
// - addr       in   32  byte address of the store
// - wdata      in   32  register value (rt); SH uses [15:0], SB uses [7:0]
// - busy       out  1   high in every state except IDLE
// - done       out  1   one-cycle pulse, operation finished (success or error)
// - err        out  1   one-cycle pulse with done; misaligned or reserved op
// - mem_addr   out  32  word address {addr_q[31:2],2'b00}
// - mem_wr     out  1   memory write enable
// - mem_wdata  out  32  merged word to write
// - mem_rdata  in   32  memory read data
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, err, mem_wr = 0; mem_addr, mem_wdata = 0; internal latches cleared.
// - IDLE + start: latch op, addr, wdata at that edge (T0). Inputs are ignored afterwards until IDLE.
// - start outside IDLE: ignored; it is not queued.
// - Error check at T0: the operation is an error in any of these cases:
//   - SW with addr[1:0]!=0
//   - SH with addr[0]=1
//   - op=11
// - Error path: ERR state at T1 with done=1 and err=1; no memory access; IDLE at T2.
// - SW path: T1=WRITE (mem_wr=1, mem_wdata=wdata_q); T2=DONE (done=1); IDLE at T3. No read is issued.
// - SB/SH path, states in order:
//   - READ: MEM_LATENCY cycles, mem_wr=0, down-counter.
//   - CAPTURE: one cycle; mem_rdata registered at its closing edge.
//   - WRITE: mem_wr=1 with merged word.
//   - DONE: done=1.
//   - For MEM_LATENCY=1: READ=T1, CAPTURE=T2, WRITE=T3, DONE=T4, IDLE at T5.
// - Merge rules, with b=addr_q[1:0]:
//   - SB replaces bits [8b+7:8b] with wdata_q[7:0].
//   - SH replaces [15:0] (b=0) or [31:16] (b=2) with wdata_q[15:0].
//   - All other bits keep the captured word.
// - mem_addr is held constant from T1 until the cycle before IDLE. mem_wr is high in WRITE only, exactly one cycle.
// - done and err are Moore outputs of DONE/ERR; never high together with mem_wr.
// - Back-to-back: start may be sampled in the IDLE cycle right after DONE. Minimum spacing is SW 3 cycles, SB/SH MEM_LATENCY+4.
// - Reset mid-operation forces IDLE at the next edge.
//   - A write already on the bus in the reset cycle completes, because memory samples it on that edge.
//   - No done pulse is produced for the aborted operation.
// - Reset with start high in the same cycle: reset wins; the request is dropped.
// TESTING
// - SB addr=0x102, wdata=0xAABBCCDD, mem[0x100]=0x11223344 -> one write at 0x100 of 0x11DD3344; done at T4; err=0.
// - SH addr=0x202, wdata=0x0000BEEF, mem[0x200]=0xCAFEF00D -> write 0xBEEFF00D at 0x200; SH addr=0x200 -> 0xCAFEBEEF.
// - SW addr=0x300, wdata=0x12345678 -> mem_wr only at T1 with 0x12345678; no read cycle; done at T2.
// - SH addr=0x201, and op=11 -> done=err=1 at T1; mem_wr never asserted; memory unchanged.
// - start pulsed during READ of an SB -> ignored, exactly one write. Reset asserted in CAPTURE -> IDLE, no write, no done.
// - MEM_LATENCY=3, SB addr=0x3, mem=0x00000000, wdata=0xFF -> 3 READ cycles, write 0xFF000000, done at T6.

Source files
------------

// File: rtl/store_size_if.sv
// store_size_if: control handshake plus data-memory port of the store size unit
interface store_size_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master (
    output start, op, addr, wdata, mem_rdata,
    input  busy, done, err, mem_addr, mem_wr, mem_wdata
  );
  modport slave (
    input  start, op, addr, wdata, mem_rdata,
    output busy, done, err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/store_size_unit.sv
// store_size_unit: narrows a register value to word/half/byte and stores it by read-modify-write
module store_size_unit #(
  parameter int MEM_LATENCY = 1
) (
  input logic         clk,
  input logic         reset,
  store_size_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE, ERR} state_t;
  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_cnt;
  logic [31:0] w_mask, w_lane, w_merged;
  logic        w_bad, w_active;
  assign w_bad = (bus.op == OP_SW && bus.addr[1:0] != 2'b00) ||
                 (bus.op == OP_SH && bus.addr[0]) || bus.op == 2'b11;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !bus.start ? IDLE : w_bad ? ERR : bus.op == OP_SW ? WRITE : READ;
      READ:    w_next = r_cnt == 3'd0 ? CAPTURE : READ;
      CAPTURE: w_next = WRITE;
      WRITE:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_op    <= bus.op;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_cnt   <= LAT_M1;
      end
      if (r_state == READ) r_cnt <= r_cnt - 3'd1;
      if (r_state == CAPTURE) r_rdata <= bus.mem_rdata;
    end
  end
  // Lane mask selects the bytes replaced by the narrowed value; the rest come from the captured word.
  assign w_mask   = r_op == OP_SB ? 32'h0000_00FF << {r_addr[1:0], 3'b000} :
                    r_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
  assign w_lane   = r_op == OP_SB ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};
  assign w_merged = r_op == OP_SW ? r_wdata : (w_lane & w_mask) | (r_rdata & ~w_mask);
  assign w_active      = r_state != IDLE;
  assign bus.busy      = w_active;
  assign bus.done      = r_state == DONE || r_state == ERR;
  assign bus.err       = r_state == ERR;
  assign bus.mem_wr    = r_state == WRITE;
  assign bus.mem_addr  = w_active ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_wdata = r_state == WRITE ? w_merged : 32'd0;
endmodule

// File: tb/tb_store_size_unit.sv
// tb_store_size_unit: scoreboard bench for store_size_unit with latency-1 and latency-3 instances
module tb_store_size_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  store_size_if bus0 ();
  store_size_if bus1 ();
  store_size_unit #(.MEM_LATENCY(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  store_size_unit #(.MEM_LATENCY(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  int rc0 = 0, rc1 = 0;
  int cyc = 0;
  int n_cmp = 0, n_fail = 0;
  always @(posedge clk) cyc++;
  // Memory models return garbage until the address has been held for the configured latency.
  always @(posedge clk) begin
    if (bus0.mem_wr) mem0[bus0.mem_addr[9:2]] <= bus0.mem_wdata;
    if (bus1.mem_wr) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
    rc0 <= (bus0.busy && !bus0.mem_wr) ? rc0 + 1 : 0;
    rc1 <= (bus1.busy && !bus1.mem_wr) ? rc1 + 1 : 0;
  end
  assign bus0.mem_rdata = rc0 >= 1 ? mem0[bus0.mem_addr[9:2]] : 32'hDEAD_BEEF;
  assign bus1.mem_rdata = rc1 >= 3 ? mem1[bus1.mem_addr[9:2]] : 32'hDEAD_BEEF;
  typedef struct {
    int          id;
    int          t0;
    int          wl;
    logic [31:0] wa;
    logic [31:0] wd;
    int          dl;
    logic        e;
  } exp_t;
  exp_t q[$];
  int          mwc [2];
  int          mwcy [2];
  logic [31:0] mwa [2];
  logic [31:0] mwd [2];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic mon(input int id, input logic d, input logic er, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd);
    exp_t x;
    if (wr || d) chk("wr_done_overlap", {31'd0, wr && d}, 32'd0);
    if (wr) begin
      mwc[id]++;
      mwcy[id] = cyc;
      mwa[id] = a;
      mwd[id] = wd;
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_write dut%0d: got write %h at %h expected none", id, wd, a);
      end
    end
    if (d) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_done dut%0d: got done expected none", id);
      end else begin
        x = q.pop_front();
        chk("done_dut", id, x.id);
        chk("done_latency", cyc - x.t0, x.dl);
        chk("err", {31'd0, er}, {31'd0, x.e});
        chk("write_count", mwc[id], x.wl < 0 ? 0 : 1);
        if (x.wl >= 0) begin
          chk("write_latency", mwcy[id] - x.t0, x.wl);
          chk("write_addr", mwa[id], x.wa);
          chk("write_data", mwd[id], x.wd);
        end
      end
      mwc[id] = 0;
    end
  endtask
  always @(negedge clk) mon(0, bus0.done, bus0.err, bus0.mem_wr, bus0.mem_addr, bus0.mem_wdata);
  always @(negedge clk) mon(1, bus1.done, bus1.err, bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata);
  task automatic issue(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input int wl, input logic [31:0] ed, input int dl, input logic e);
    exp_t x;
    x.id = id; x.t0 = cyc; x.wl = wl; x.wa = {a[31:2], 2'b00}; x.wd = ed; x.dl = dl; x.e = e;
    q.push_back(x);
    if (id == 0) begin
      bus0.start = 1'b1; bus0.op = op; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.start = 1'b1; bus1.op = op; bus1.addr = a; bus1.wdata = d;
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask
  task automatic wait_idle(input int id);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(id == 0 ? bus0.busy : bus1.busy)) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL timeout dut%0d: got busy stuck expected idle", id);
  endtask
  initial begin
    bus0.start = 1'b0; bus0.op = 2'b00; bus0.addr = 32'd0; bus0.wdata = 32'd0;
    bus1.start = 1'b0; bus1.op = 2'b00; bus1.addr = 32'd0; bus1.wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'd0;
      mem1[i] = 32'd0;
    end
    mwc = '{0, 0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
    chk("rst_done", {31'd0, bus0.done}, 32'd0);
    chk("rst_err", {31'd0, bus0.err}, 32'd0);
    chk("rst_mem_wr", {31'd0, bus0.mem_wr}, 32'd0);
    chk("rst_mem_addr", bus0.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus0.mem_wdata, 32'd0);
    @(negedge clk);
    mem0[8'h40] = 32'h1122_3344;
    issue(0, 2'b10, 32'h102, 32'hAABB_CCDD, 3, 32'h11DD_3344, 4, 1'b0);
    wait_idle(0);
    chk("mem_sb", mem0[8'h40], 32'h11DD_3344);
    mem0[8'h80] = 32'hCAFE_F00D;
    issue(0, 2'b01, 32'h202, 32'h0000_BEEF, 3, 32'hBEEF_F00D, 4, 1'b0);
    wait_idle(0);
    chk("mem_sh_hi", mem0[8'h80], 32'hBEEF_F00D);
    mem0[8'h80] = 32'hCAFE_F00D;
    issue(0, 2'b01, 32'h200, 32'h0000_BEEF, 3, 32'hCAFE_BEEF, 4, 1'b0);
    wait_idle(0);
    chk("mem_sh_lo", mem0[8'h80], 32'hCAFE_BEEF);
    issue(0, 2'b00, 32'h300, 32'h1234_5678, 1, 32'h1234_5678, 2, 1'b0);
    wait_idle(0);
    chk("mem_sw", mem0[8'hC0], 32'h1234_5678);
    issue(0, 2'b01, 32'h201, 32'h0000_0000, -1, 32'd0, 1, 1'b1);
    wait_idle(0);
    issue(0, 2'b11, 32'h300, 32'hFFFF_FFFF, -1, 32'd0, 1, 1'b1);
    wait_idle(0);
    issue(0, 2'b00, 32'h302, 32'hFFFF_FFFF, -1, 32'd0, 1, 1'b1);
    wait_idle(0);
    chk("mem_after_err_sw", mem0[8'hC0], 32'h1234_5678);
    chk("mem_after_err_sh", mem0[8'h80], 32'hCAFE_BEEF);
    issue(0, 2'b10, 32'h101, 32'h0000_0055, 3, 32'h11DD_5544, 4, 1'b0);
    bus0.start = 1'b1; bus0.op = 2'b00; bus0.addr = 32'h300; bus0.wdata = 32'd0;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("mem_ignored_start", mem0[8'hC0], 32'h1234_5678);
    chk("mem_sb_lane1", mem0[8'h40], 32'h11DD_5544);
    bus0.start = 1'b1; bus0.op = 2'b10; bus0.addr = 32'h103; bus0.wdata = 32'h0000_0099;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus0.busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_mem", mem0[8'h40], 32'h11DD_5544);
    reset = 1'b1;
    bus0.start = 1'b1; bus0.op = 2'b00; bus0.addr = 32'h300; bus0.wdata = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    bus0.start = 1'b0;
    chk("rst_start_busy", {31'd0, bus0.busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_start_mem", mem0[8'hC0], 32'h1234_5678);
    mem1[0] = 32'h0000_0000;
    issue(1, 2'b10, 32'h3, 32'h0000_00FF, 5, 32'hFF00_0000, 6, 1'b0);
    wait_idle(1);
    chk("mem_lat3", mem1[0], 32'hFF00_0000);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
